// File: rtl/dm_axi_master.sv
// CPU data-memory port to AXI4 master bridge: one single-beat read or write in flight at a time,
// stalling the CPU until the bus transfer completes.
module dm_axi_master #(
  parameter logic [31:0] BASE_ADDR = 32'h0001_0000,
  parameter logic [3:0]  AXI_ID    = 4'd1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        DM_CEB,
  input  logic        dm_web,
  input  logic [14:0] dm_addr,
  input  logic [31:0] dm_data_in,
  input  logic [31:0] dm_bweb,
  output logic        DM_STOP,
  output logic [31:0] dm_data_out,
  output logic        dm_bus_err,
  output logic [3:0]  ARID,
  output logic [31:0] ARADDR,
  output logic [3:0]  ARLEN,
  output logic [2:0]  ARSIZE,
  output logic [1:0]  ARBURST,
  output logic        ARVALID,
  input  logic        ARREADY,
  input  logic [3:0]  RID,
  input  logic [31:0] RDATA,
  input  logic [1:0]  RRESP,
  input  logic        RLAST,
  input  logic        RVALID,
  output logic        RREADY,
  output logic [3:0]  AWID,
  output logic [31:0] AWADDR,
  output logic [3:0]  AWLEN,
  output logic [2:0]  AWSIZE,
  output logic [1:0]  AWBURST,
  output logic        AWVALID,
  input  logic        AWREADY,
  output logic [31:0] WDATA,
  output logic [3:0]  WSTRB,
  output logic        WLAST,
  output logic        WVALID,
  input  logic        WREADY,
  input  logic [3:0]  BID,
  input  logic [1:0]  BRESP,
  input  logic        BVALID,
  output logic        BREADY
);

  typedef enum logic [2:0] {StIdle, StRdAddr, StRdData, StWrReq, StWrResp, StDone} state_e;

  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic        aw_done_q, aw_done_d;
  logic        w_done_q, w_done_d;
  logic [31:0] rdata_q, rdata_d;
  logic        bus_err_q, bus_err_d;
  logic        aw_hs, w_hs;

  // IDs, RLAST and the non-sampled mask bits carry no information for single-beat transfers.
  logic unused_inputs;
  assign unused_inputs = ^{RID, RLAST, BID, dm_bweb};

  assign ARID    = AXI_ID;
  assign AWID    = AXI_ID;
  assign ARLEN   = 4'd0;
  assign AWLEN   = 4'd0;
  assign ARSIZE  = 3'b010;
  assign AWSIZE  = 3'b010;
  assign ARBURST = 2'b01;
  assign AWBURST = 2'b01;
  assign WLAST   = 1'b1;
  assign ARADDR  = addr_q;
  assign AWADDR  = addr_q;
  assign WDATA   = wdata_q;
  assign WSTRB   = wstrb_q;
  assign dm_data_out = rdata_q;
  assign dm_bus_err  = bus_err_q;

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    rdata_d   = rdata_q;
    bus_err_d = bus_err_q;
    DM_STOP   = 1'b0;
    ARVALID   = 1'b0;
    RREADY    = 1'b0;
    AWVALID   = 1'b0;
    WVALID    = 1'b0;
    BREADY    = 1'b0;
    aw_hs     = 1'b0;
    w_hs      = 1'b0;
    unique case (state_q)
      StIdle: begin
        DM_STOP = ~DM_CEB;
        if (!DM_CEB) begin
          addr_d    = BASE_ADDR + {15'b0, dm_addr, 2'b00};
          wdata_d   = dm_data_in;
          wstrb_d   = ~{dm_bweb[24], dm_bweb[16], dm_bweb[8], dm_bweb[0]};
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_d   = dm_web ? StRdAddr : StWrReq;
        end
      end
      StRdAddr: begin
        DM_STOP = 1'b1;
        ARVALID = 1'b1;
        if (ARREADY) state_d = StRdData;
      end
      StRdData: begin
        DM_STOP = 1'b1;
        RREADY  = 1'b1;
        if (RVALID) begin
          rdata_d = RDATA;
          if (RRESP != 2'b00) bus_err_d = 1'b1;
          state_d = StDone;
        end
      end
      StWrReq: begin
        DM_STOP = 1'b1;
        AWVALID = ~aw_done_q;
        WVALID  = ~w_done_q;
        aw_hs   = AWVALID & AWREADY;
        w_hs    = WVALID & WREADY;
        // Both channels may finish in the same cycle or in either order.
        if ((aw_done_q | aw_hs) && (w_done_q | w_hs)) begin
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_d   = StWrResp;
        end else begin
          aw_done_d = aw_done_q | aw_hs;
          w_done_d  = w_done_q | w_hs;
        end
      end
      StWrResp: begin
        DM_STOP = 1'b1;
        BREADY  = 1'b1;
        if (BVALID) begin
          if (BRESP != 2'b00) bus_err_d = 1'b1;
          state_d = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      addr_q    <= 32'd0;
      wdata_q   <= 32'd0;
      wstrb_q   <= 4'd0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      rdata_q   <= 32'd0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      rdata_q   <= rdata_d;
      bus_err_q <= bus_err_d;
    end
  end

endmodule

// File: tb/tb_dm_axi_master.sv
// Directed bench for dm_axi_master: inputs driven on the falling edge, outputs checked 1ns later.
module tb_dm_axi_master;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        DM_CEB = 1'b1, dm_web = 1'b1;
  logic [14:0] dm_addr = '0;
  logic [31:0] dm_data_in = '0, dm_bweb = '1;
  logic        DM_STOP, dm_bus_err;
  logic [31:0] dm_data_out;
  logic [3:0]  ARID, ARLEN, AWID, AWLEN;
  logic [31:0] ARADDR, AWADDR, WDATA;
  logic [2:0]  ARSIZE, AWSIZE;
  logic [1:0]  ARBURST, AWBURST;
  logic        ARVALID, RREADY, AWVALID, WVALID, WLAST, BREADY;
  logic [3:0]  WSTRB;
  logic        ARREADY = 0, RLAST = 1, RVALID = 0, AWREADY = 0, WREADY = 0, BVALID = 0;
  logic [3:0]  RID = 4'd1, BID = 4'd1;
  logic [31:0] RDATA = '0;
  logic [1:0]  RRESP = '0, BRESP = '0;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  dm_axi_master dut (
    .clk(clk), .rst(rst), .DM_CEB(DM_CEB), .dm_web(dm_web), .dm_addr(dm_addr),
    .dm_data_in(dm_data_in), .dm_bweb(dm_bweb), .DM_STOP(DM_STOP), .dm_data_out(dm_data_out),
    .dm_bus_err(dm_bus_err), .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE),
    .ARBURST(ARBURST), .ARVALID(ARVALID), .ARREADY(ARREADY), .RID(RID), .RDATA(RDATA),
    .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY), .AWID(AWID),
    .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST), .AWVALID(AWVALID),
    .AWREADY(AWREADY), .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID),
    .WREADY(WREADY), .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY)
  );

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    n_checks++;
    if ({DM_STOP, ARVALID, RREADY, AWVALID, WVALID, BREADY} !== 6'b0) begin
      n_fail++;
      $display("FAIL rst_ctrl: got %b exp %b",
               {DM_STOP, ARVALID, RREADY, AWVALID, WVALID, BREADY}, 6'b0);
    end
    n_checks++;
    if ({dm_data_out, dm_bus_err} !== 33'd0) begin
      n_fail++; $display("FAIL rst_data_err: got %h/%b exp 0/0", dm_data_out, dm_bus_err);
    end
    n_checks++;
    if ({ARID, ARLEN, ARSIZE, ARBURST, AWID, AWLEN, AWSIZE, AWBURST, WLAST} !==
        {4'd1, 4'd0, 3'b010, 2'b01, 4'd1, 4'd0, 3'b010, 2'b01, 1'b1}) begin
      n_fail++;
      $display("FAIL consts: got %h exp %h",
               {ARID, ARLEN, ARSIZE, ARBURST, AWID, AWLEN, AWSIZE, AWBURST, WLAST},
               {4'd1, 4'd0, 3'b010, 2'b01, 4'd1, 4'd0, 3'b010, 2'b01, 1'b1});
    end
    // Stall is combinational on the request in IDLE; withdrawn before the clock edge.
    DM_CEB = 1'b0;
    #1;
    n_checks++;
    if (DM_STOP !== 1'b1) begin n_fail++; $display("FAIL idle_req_stop: got %b exp 1", DM_STOP); end
    DM_CEB = 1'b1;
  endtask

  task automatic test_read_basic;
    @(negedge clk);
    ARREADY = 1; RVALID = 1; RDATA = 32'hDEAD_BEEF; RRESP = 0;
    DM_CEB = 0; dm_web = 1; dm_addr = 15'h0004;
    #1;
    n_checks++;
    if ({DM_STOP, ARVALID, RREADY} !== 3'b100) begin
      n_fail++; $display("FAIL rd_c1: got %b exp 100", {DM_STOP, ARVALID, RREADY});
    end
    @(negedge clk); DM_CEB = 1; #1;
    n_checks++;
    if ({DM_STOP, ARVALID, RREADY, ARADDR} !== {3'b110, 32'h0001_0010}) begin
      n_fail++; $display("FAIL rd_addr: got %b %h exp 110 00010010", {DM_STOP, ARVALID, RREADY}, ARADDR);
    end
    @(negedge clk); #1;
    n_checks++;
    if ({DM_STOP, ARVALID, RREADY} !== 3'b101) begin
      n_fail++; $display("FAIL rd_data: got %b exp 101", {DM_STOP, ARVALID, RREADY});
    end
    @(negedge clk); #1;
    n_checks++;
    if ({DM_STOP, ARVALID, RREADY, dm_data_out} !== {3'b000, 32'hDEAD_BEEF}) begin
      n_fail++; $display("FAIL rd_done: got %b %h exp 000 deadbeef", {DM_STOP, ARVALID, RREADY}, dm_data_out);
    end
    @(negedge clk); ARREADY = 0; RVALID = 0; #1;
    n_checks++;
    if ({DM_STOP, dm_data_out} !== {1'b0, 32'hDEAD_BEEF}) begin
      n_fail++; $display("FAIL rd_hold: got %b %h exp 0 deadbeef", DM_STOP, dm_data_out);
    end
  endtask

  task automatic test_write_delay;
    @(negedge clk);
    AWREADY = 0; WREADY = 1; BVALID = 0;
    DM_CEB = 0; dm_web = 0; dm_addr = 15'h0010; dm_data_in = 32'h1234_5678; dm_bweb = 32'hFFFF_0000;
    #1;
    @(negedge clk); DM_CEB = 1; dm_web = 1; #1;
    n_checks++;
    if ({DM_STOP, AWVALID, WVALID, BREADY, AWADDR, WDATA, WSTRB} !==
        {4'b1110, 32'h0001_0040, 32'h1234_5678, 4'b0011}) begin
      n_fail++;
      $display("FAIL wr_req: got %b %h %h %b exp 1110 00010040 12345678 0011",
               {DM_STOP, AWVALID, WVALID, BREADY}, AWADDR, WDATA, WSTRB);
    end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      if (i == 1) AWREADY = 1;
      #1;
      n_checks++;
      if ({DM_STOP, AWVALID, WVALID, BREADY} !== 4'b1100) begin
        n_fail++; $display("FAIL wr_aw_wait%0d: got %b exp 1100", i, {DM_STOP, AWVALID, WVALID, BREADY});
      end
    end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      AWREADY = 0;
      if (i == 1) begin BVALID = 1; BRESP = 0; end
      #1;
      n_checks++;
      if ({DM_STOP, AWVALID, WVALID, BREADY} !== 4'b1001) begin
        n_fail++; $display("FAIL wr_resp%0d: got %b exp 1001", i, {DM_STOP, AWVALID, WVALID, BREADY});
      end
    end
    @(negedge clk); BVALID = 0; #1;
    n_checks++;
    if ({DM_STOP, BREADY, dm_data_out, dm_bus_err} !== {2'b00, 32'hDEAD_BEEF, 1'b0}) begin
      n_fail++;
      $display("FAIL wr_done: got %b %h %b exp 00 deadbeef 0", {DM_STOP, BREADY}, dm_data_out, dm_bus_err);
    end
  endtask

  task automatic test_read_stall;
    @(negedge clk);
    ARREADY = 0; RVALID = 0; DM_CEB = 0; dm_web = 1; dm_addr = 15'h7FFF;
    #1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      DM_CEB = 1;
      if (i == 5) ARREADY = 1;
      #1;
      n_checks++;
      if ({DM_STOP, ARVALID, RREADY, ARADDR} !== {3'b110, 32'h0002_FFFC}) begin
        n_fail++;
        $display("FAIL rd_stall%0d: got %b %h exp 110 0002fffc", i, {DM_STOP, ARVALID, RREADY}, ARADDR);
      end
    end
    @(negedge clk); ARREADY = 0; RVALID = 1; RDATA = 32'hA5A5_0F0F; #1;
    n_checks++;
    if ({DM_STOP, ARVALID, RREADY} !== 3'b101) begin
      n_fail++; $display("FAIL rd_stall_data: got %b exp 101", {DM_STOP, ARVALID, RREADY});
    end
    @(negedge clk); RVALID = 0; #1;
    n_checks++;
    if ({DM_STOP, dm_data_out} !== {1'b0, 32'hA5A5_0F0F}) begin
      n_fail++; $display("FAIL rd_stall_done: got %b %h exp 0 a5a50f0f", DM_STOP, dm_data_out);
    end
  endtask

  task automatic test_write_err;
    @(negedge clk);
    AWREADY = 1; WREADY = 1; BVALID = 1; BRESP = 2'b10;
    RVALID = 1; RDATA = 32'hFFFF_FFFF; RRESP = 2'b10;
    DM_CEB = 0; dm_web = 0; dm_addr = 15'h0000; dm_data_in = 32'hCAFE_F00D; dm_bweb = 32'h00FF_00FF;
    #1;
    @(negedge clk); DM_CEB = 1; dm_web = 1; #1;
    n_checks++;
    if ({DM_STOP, AWVALID, WVALID, BREADY, AWADDR, WSTRB} !== {4'b1110, 32'h0001_0000, 4'b1010}) begin
      n_fail++;
      $display("FAIL wr_same_cycle: got %b %h %b exp 1110 00010000 1010",
               {DM_STOP, AWVALID, WVALID, BREADY}, AWADDR, WSTRB);
    end
    @(negedge clk); #1;
    n_checks++;
    if ({DM_STOP, AWVALID, WVALID, BREADY, dm_bus_err} !== 5'b10010) begin
      n_fail++; $display("FAIL wr_err_resp: got %b exp 10010", {DM_STOP, AWVALID, WVALID, BREADY, dm_bus_err});
    end
    @(negedge clk); BVALID = 0; RVALID = 0; RRESP = 0; #1;
    n_checks++;
    if ({DM_STOP, dm_bus_err, dm_data_out} !== {2'b01, 32'hA5A5_0F0F}) begin
      n_fail++; $display("FAIL wr_err_done: got %b %b %h exp 0 1 a5a50f0f", DM_STOP, dm_bus_err, dm_data_out);
    end
  endtask

  task automatic test_back_to_back;
    @(negedge clk);
    ARREADY = 1; RVALID = 1; RRESP = 0; RDATA = 32'h1111_1111;
    DM_CEB = 0; dm_web = 1; dm_addr = 15'h0001;
    #1;
    @(negedge clk); #1;
    n_checks++;
    if ({DM_STOP, ARVALID, RREADY, ARADDR} !== {3'b110, 32'h0001_0004}) begin
      n_fail++; $display("FAIL b2b_addr1: got %b %h exp 110 00010004", {DM_STOP, ARVALID, RREADY}, ARADDR);
    end
    @(negedge clk); #1;
    @(negedge clk); dm_addr = 15'h0002; #1;
    n_checks++;
    if ({DM_STOP, ARVALID, RREADY, dm_data_out} !== {3'b000, 32'h1111_1111}) begin
      n_fail++;
      $display("FAIL b2b_done1: got %b %h exp 000 11111111", {DM_STOP, ARVALID, RREADY}, dm_data_out);
    end
    @(negedge clk); RDATA = 32'h2222_2222; #1;
    n_checks++;
    if ({DM_STOP, ARVALID, RREADY} !== 3'b100) begin
      n_fail++; $display("FAIL b2b_accept2: got %b exp 100", {DM_STOP, ARVALID, RREADY});
    end
    @(negedge clk); DM_CEB = 1; #1;
    n_checks++;
    if ({DM_STOP, ARVALID, RREADY, ARADDR} !== {3'b110, 32'h0001_0008}) begin
      n_fail++; $display("FAIL b2b_addr2: got %b %h exp 110 00010008", {DM_STOP, ARVALID, RREADY}, ARADDR);
    end
    @(negedge clk); #1;
    @(negedge clk); RVALID = 0; ARREADY = 0; #1;
    n_checks++;
    if ({DM_STOP, ARVALID, RREADY, dm_data_out, dm_bus_err} !== {3'b000, 32'h2222_2222, 1'b1}) begin
      n_fail++;
      $display("FAIL b2b_done2: got %b %h %b exp 000 22222222 1",
               {DM_STOP, ARVALID, RREADY}, dm_data_out, dm_bus_err);
    end
    @(negedge clk); #1;
    n_checks++;
    if ({DM_STOP, ARVALID, RREADY} !== 3'b000) begin
      n_fail++; $display("FAIL b2b_no_extra: got %b exp 000", {DM_STOP, ARVALID, RREADY});
    end
  endtask

  task automatic test_reset_mid;
    @(negedge clk);
    ARREADY = 1; RVALID = 0; DM_CEB = 0; dm_web = 1; dm_addr = 15'h0003;
    #1;
    @(negedge clk); DM_CEB = 1; #1;
    @(negedge clk); #1;
    n_checks++;
    if ({DM_STOP, ARVALID, RREADY} !== 3'b101) begin
      n_fail++; $display("FAIL rst_mid_pre: got %b exp 101", {DM_STOP, ARVALID, RREADY});
    end
    rst = 1;
    @(negedge clk); rst = 0; #1;
    n_checks++;
    if ({DM_STOP, ARVALID, RREADY, dm_data_out, dm_bus_err} !== 36'd0) begin
      n_fail++;
      $display("FAIL rst_mid: got %b %h %b exp 000 0 0", {DM_STOP, ARVALID, RREADY}, dm_data_out, dm_bus_err);
    end
    @(negedge clk); ARREADY = 0; #1;
    n_checks++;
    if ({DM_STOP, ARVALID, RREADY} !== 3'b000) begin
      n_fail++; $display("FAIL rst_mid_idle: got %b exp 000", {DM_STOP, ARVALID, RREADY});
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout exp finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_read_basic();
    test_write_delay();
    test_read_stall();
    test_write_err();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
